// File: rtl/cnn_pkg.sv
// Constants and helpers shared by the CNN datapath stages (convolution and pooling).
package cnn_pkg;
  localparam int CNN_W  = 32;
  localparam int CNN_H  = 32;
  localparam int CNN_DW = 8;

  // Callers sign-extend narrower samples into this width and truncate the result back.
  localparam int MAX2_W = 32;

  function automatic logic signed [MAX2_W-1:0] max2(input logic signed [MAX2_W-1:0] a,
                                                    input logic signed [MAX2_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pool_row_buffer.sv
// Half-width row buffer holding the horizontal partial maxima of the even row.
module pool_row_buffer #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);
  logic signed [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/conv_maxpool_2x2.sv
// Optional ReLU plus 2x2 stride-2 max-pooling over a raster-order signed feature map.
module conv_maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int W    = CNN_W,
  parameter int H    = CNN_H,
  parameter int DW   = CNN_DW,
  parameter bit RELU = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic                 dout_valid,
  output logic signed [DW-1:0] dout,
  output logic                 dout_last
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int AW = (W > 2) ? $clog2(W / 2) : 1;

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic signed [DW-1:0] h_reg;
  logic signed [DW-1:0] rb_rdata;
  logic signed [DW-1:0] m;
  logic signed [DW-1:0] p_max;
  logic signed [DW-1:0] p;
  logic [AW-1:0]        rb_addr;
  logic                 col_last;
  logic                 row_last;
  logic                 rb_we;

  assign col_last = (col == CW'(W - 1));
  assign row_last = (row == RW'(H - 1));
  assign rb_addr  = AW'(col >> 1);

  assign m     = DW'(max2(MAX2_W'(h_reg), MAX2_W'(din)));
  assign p_max = DW'(max2(MAX2_W'(rb_rdata), MAX2_W'(m)));
  assign p     = (RELU && (p_max < 0)) ? '0 : p_max;

  // Even rows park their horizontal maxima; odd rows at the same column read them back.
  assign rb_we = din_valid && !clr && col[0] && !row[0];

  pool_row_buffer #(
    .DEPTH (W / 2),
    .DW    (DW),
    .AW    (AW)
  ) u_rowbuf (
    .clk   (clk),
    .we    (rb_we),
    .waddr (rb_addr),
    .wdata (m),
    .raddr (rb_addr),
    .rdata (rb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      h_reg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      if (clr) begin
        col   <= '0;
        row   <= '0;
        h_reg <= '0;
      end else if (din_valid) begin
        if (!col[0]) begin
          h_reg <= din;
        end else if (row[0]) begin
          dout       <= p;
          dout_valid <= 1'b1;
          dout_last  <= row_last && col_last;
        end
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Randomised directed bench: two instances (RELU=0/1) share stimulus and are checked against an image-based 2x2 max model.
module tb_conv_maxpool_2x2;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic din_valid = 1'b0;
  logic signed [DW-1:0] din = '0;

  logic dout_valid0, dout_last0, dout_valid1, dout_last1;
  logic signed [DW-1:0] dout0, dout1;

  conv_maxpool_2x2 #(.W(W), .H(H), .DW(DW), .RELU(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid0), .dout(dout0), .dout_last(dout_last0));

  conv_maxpool_2x2 #(.W(W), .H(H), .DW(DW), .RELU(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid1), .dout(dout1), .dout_last(dout_last1));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int img [H][W];
  int r = 0, c = 0;
  int last0 = 0, last1 = 0;
  int pulses = 0;
  int exp_max = 0;
  bit exp_v = 1'b0, exp_l = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic int max4(input int a, input int b, input int d, input int e);
    int mx;
    mx = a;
    if (b > mx) mx = b;
    if (d > mx) mx = d;
    if (e > mx) mx = e;
    return mx;
  endfunction

  function automatic int pix(input int mode, input int rr, input int cc);
    int blk [4] = '{-128, 127, -1, 0};
    case (mode)
      0: return (rr * 32 + cc) % 100;
      1: return (rr == 4 && cc == 6) ? 100 : 0;
      2: return (rr == 4 && cc == 6) ? -100 : 0;
      4: return -5;
      5: if (rr < 2 && cc < 2) return blk[rr * 2 + cc];
         else return int'($urandom_range(0, 255)) - 128;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic check_outputs();
    if (exp_v) begin
      last0 = exp_max;
      last1 = (exp_max < 0) ? 0 : exp_max;
    end
    chk("valid0", 32'(dout_valid0), 32'(exp_v));
    chk("last0",  32'(dout_last0),  32'(exp_l));
    chk("dout0",  32'(dout0),       last0);
    chk("valid1", 32'(dout_valid1), 32'(exp_v));
    chk("last1",  32'(dout_last1),  32'(exp_l));
    chk("dout1",  32'(dout1),       last1);
  endtask

  task automatic step(input bit v, input int d, input bit cl);
    @(negedge clk);
    din_valid = v;
    din = DW'(d);
    clr = cl;
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    exp_l = 1'b0;
    if (cl) begin
      r = 0;
      c = 0;
    end else if (v) begin
      img[r][c] = d;
      if (r % 2 == 1 && c % 2 == 1) begin
        exp_v = 1'b1;
        exp_max = max4(img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c]);
        exp_l = (r == H - 1) && (c == W - 1);
        pulses++;
      end
      if (c == W - 1) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end else begin
        c++;
      end
    end
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b1;
    din = DW'(int'($urandom_range(0, 255)) - 128);
    rst_n = 1'b0;
    #1;
    exp_v = 1'b0;
    exp_l = 1'b0;
    last0 = 0;
    last1 = 0;
    check_outputs();
    r = 0;
    c = 0;
    @(negedge clk);
    din_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // ab_kind: 0 none, 1 clr with a valid sample at (ab_r,ab_c), 2 reset at (ab_r,ab_c).
  task automatic run_frame(input int mode, input int gap_pct,
                           input int ab_r, input int ab_c, input int ab_kind);
    pulses = 0;
    for (int rr = 0; rr < H; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        while (int'($urandom_range(0, 99)) < gap_pct)
          step(1'b0, int'($urandom_range(0, 255)) - 128, 1'b0);
        if (ab_kind != 0 && rr == ab_r && cc == ab_c) begin
          if (ab_kind == 1) step(1'b1, pix(mode, rr, cc), 1'b1);
          else do_reset();
          return;
        end
        step(1'b1, pix(mode, rr, cc), 1'b0);
      end
    end
    chk("pulses", pulses, (W / 2) * (H / 2));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    exp_v = 1'b0;
    exp_l = 1'b0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0);
    run_frame(2, 0, 0, 0, 0);
    run_frame(5, 0, 0, 0, 0);
    run_frame(4, 0, 0, 0, 0);
    run_frame(3, 0, 0, 0, 0);
    run_frame(0, 30, 0, 0, 0);
    run_frame(0, 0, 7, 13, 1);
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 10, 20, 0, 2);
    run_frame(0, 10, 0, 0, 0);
    run_frame(3, 30, 0, 0, 0);
    repeat (3) step(1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
